piso_serializer: RTL and testbench
==================================

Name: piso_serializer

Overview:
Parametrised parallel-in/serial-out engine for the UART transmit path; the next generation of the 8-bit serializer.
- Accepts words over a valid/ready handshake into a one-deep holding register, so the frame controller can queue the next word while the current one shifts.
- Shifts LSB- or MSB-first at one bit per ser_en cycle and supplies a precomputed parity bit to the frame controller.
- Reloads back-to-back with no idle gap and flags underrun.

Parameters:
DATA_WIDTH, 8, word width in bits (≥2)
LSB_FIRST, 1, 1 = bit 0 first; 0 = bit DATA_WIDTH-1 first
IDLE_LEVEL, 1'b0, ser_data value after reset and on underrun
CNT_WIDTH, $clog2(DATA_WIDTH+1), bit-counter width (localparam, not overridable)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
P_DATA  in  DATA_WIDTH  parallel word
Data_Valid  in  1  P_DATA valid
data_ready  out  1  holding register empty; word accepted when Data_Valid && data_ready
par_odd  in  1  0 = even parity, 1 = odd; sampled when a word enters the shifter
ser_en  in  1  advance one bit this cycle
ser_data  out  1  registered serial bit
ser_done  out  1  one-cycle pulse, high in the cycle the last bit is on ser_data
par_bit  out  1  parity of the word in the shifter, registered
busy  out  1  shifter loaded or holding register full
underrun  out  1  one-cycle pulse: ser_en with shifter empty

Behaviour:
- Reset (rst=1 at edge): shifter and hold empty, cnt=0, state IDLE, ser_data=IDLE_LEVEL, ser_done=0, par_bit=0, underrun=0, busy=0. data_ready=1 from the next cycle. Reset wins over all other inputs, including mid-frame; a partially shifted word is discarded.
- data_ready = !hold_full (combinational from state, no dependence on Data_Valid).
- State machine:
  - IDLE: shifter empty.
  - LOADED: word in shifter, cnt=DATA_WIDTH remaining.
  - SHIFT: 0 < cnt < DATA_WIDTH.
- Load rule:
  - When the shifter is empty at an edge, it loads from hold if hold is full. Otherwise it loads directly from P_DATA if a handshake occurs (bypass, 1-cycle latency).
  - On load: par_bit <= (^word) ^ par_odd; cnt <= DATA_WIDTH; go to LOADED.
- Shift rule:
  - ser_en=1 in LOADED/SHIFT: ser_data <= next bit (index 0 upward if LSB_FIRST, else DATA_WIDTH-1 downward); cnt decrements.
  - The edge that presents the final bit also sets ser_done=1 for exactly that cycle.
  - On that same edge the shifter reloads from hold if hold is full, giving zero gap; otherwise it goes to IDLE.
- ser_en=0: shifter, cnt, ser_data and par_bit hold (pause mid-frame permitted).
- ser_en=1 in IDLE, or in the same edge as a bypass load: ser_data <= IDLE_LEVEL, underrun=1 for one cycle, no shift.
- Simultaneous hold→shifter transfer and a new handshake: legal only if hold was empty before the edge, since data_ready gates it. A word never overwrites a full hold.
- par_bit changes only on load; it stays stable through the whole frame, including the ser_done cycle.
- busy = (state != IDLE) || hold_full.

Decomposition:
- Shared package/include ser_pkg: state encodings (IDLE, LOADED, SHIFT) and a parity helper function.
- One natural sub-module: ser_shift_reg, covering the shifter, counter, bit select by LSB_FIRST and ser_data register. Top level keeps the hold register, handshake, FSM and flags.

Test Plan:
- DATA_WIDTH=8, LSB_FIRST=1, par_odd=0, P_DATA=8'h01, then ser_en held high 8 cycles -> ser_data 1,0,0,0,0,0,0,0; ser_done high on 8th bit only; par_bit=1.
- LSB_FIRST=0, par_odd=1, P_DATA=8'h01, 8 ser_en cycles -> ser_data 0,0,0,0,0,0,0,1; par_bit=0.
- Queue 8'hF0 then 8'h0F, ser_en continuous 16 cycles -> LSB-first 0,0,0,0,1,1,1,1,1,1,1,1,0,0,0,0 with no gap; ser_done on cycles 8 and 16; data_ready low from second accept until first reload.
- Backpressure: Data_Valid held with three words while ser_en=0 -> two accepted (bypass + hold), data_ready=0, third held until the first frame completes.
- Pause: ser_en low for 5 cycles after bit 3 of 8'hA5 -> ser_data and par_bit frozen, then the frame resumes at bit 4; exactly one ser_done.
- Underrun and reset: ser_en=1 while IDLE -> underrun one cycle, ser_data=IDLE_LEVEL. rst asserted after bit 3 -> next edge all outputs at reset values, data_ready=1, no ser_done.

Source files
------------

// File: rtl/ser_pkg.sv
// Shared definitions for the parallel-in/serial-out transmit engine:
// shifter state encoding and the parity helper used on every load.
package ser_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOADED = 2'd1,
    ST_SHIFT  = 2'd2
  } ser_state_e;

  // Words are zero-extended to this width before reduction; zero padding
  // leaves the XOR reduction unchanged.
  localparam int PAR_MAX_W = 64;

  function automatic logic parity_of(input logic [PAR_MAX_W-1:0] word,
                                     input logic                 odd);
    return (^word) ^ odd;
  endfunction

endpackage

// File: rtl/ser_shift_reg.sv
// Shift register, remaining-bit counter and registered serial output.
// A load in the same cycle as a shift replaces the word after the outgoing bit is taken.
module ser_shift_reg #(
  parameter int   DATA_WIDTH = 8,
  parameter bit   LSB_FIRST  = 1'b1,
  parameter logic IDLE_LEVEL = 1'b0,
  parameter int   CNT_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_i,
  input  logic [DATA_WIDTH-1:0] load_word_i,
  input  logic                  shift_i,
  input  logic                  idle_out_i,
  output logic [CNT_WIDTH-1:0]  cnt_o,
  output logic                  ser_data_o
);

  logic [DATA_WIDTH-1:0] sh_q, sh_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  ser_q, ser_d;

  always_comb begin
    sh_d  = sh_q;
    cnt_d = cnt_q;
    ser_d = ser_q;
    if (shift_i) begin
      if (LSB_FIRST) begin
        ser_d = sh_q[0];
        sh_d  = sh_q >> 1;
      end else begin
        ser_d = sh_q[DATA_WIDTH-1];
        sh_d  = sh_q << 1;
      end
      cnt_d = cnt_q - 1'b1;
    end else if (idle_out_i) begin
      ser_d = IDLE_LEVEL;
    end
    if (load_i) begin
      sh_d  = load_word_i;
      cnt_d = CNT_WIDTH'(DATA_WIDTH);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      ser_q <= IDLE_LEVEL;
    end else begin
      cnt_q <= cnt_d;
      ser_q <= ser_d;
    end
  end

  // Word contents are qualified by the counter, so they need no reset.
  always_ff @(posedge clk) begin
    sh_q <= sh_d;
  end

  assign cnt_o      = cnt_q;
  assign ser_data_o = ser_q;

endmodule

// File: rtl/piso_serializer.sv
// UART transmit serializer: one-deep holding register with valid/ready
// intake, zero-gap reload into the shifter, parity and underrun flags.
module piso_serializer
  import ser_pkg::*;
#(
  parameter int   DATA_WIDTH = 8,
  parameter bit   LSB_FIRST  = 1'b1,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  output logic                  data_ready,
  input  logic                  par_odd,
  input  logic                  ser_en,
  output logic                  ser_data,
  output logic                  ser_done,
  output logic                  par_bit,
  output logic                  busy,
  output logic                  underrun
);

  localparam int CNT_WIDTH = $clog2(DATA_WIDTH + 1);

  ser_state_e            state_q, state_d;
  logic [DATA_WIDTH-1:0] hold_q, hold_d;
  logic                  hold_full_q, hold_full_d;
  logic                  par_q, par_d;
  logic                  done_q, done_d;
  logic                  under_q, under_d;

  logic                  hs, shift, last, idle_out, load, bypass;
  logic [DATA_WIDTH-1:0] load_word;
  logic [CNT_WIDTH-1:0]  cnt;

  ser_shift_reg #(
    .DATA_WIDTH (DATA_WIDTH),
    .LSB_FIRST  (LSB_FIRST),
    .IDLE_LEVEL (IDLE_LEVEL),
    .CNT_WIDTH  (CNT_WIDTH)
  ) u_shift (
    .clk         (clk),
    .rst         (rst),
    .load_i      (load),
    .load_word_i (load_word),
    .shift_i     (shift),
    .idle_out_i  (idle_out),
    .cnt_o       (cnt),
    .ser_data_o  (ser_data)
  );

  always_comb begin
    hs        = Data_Valid && !hold_full_q;
    shift     = (state_q != ST_IDLE) && ser_en;
    last      = shift && (cnt == CNT_WIDTH'(1));
    idle_out  = (state_q == ST_IDLE) && ser_en;
    load      = 1'b0;
    bypass    = 1'b0;
    load_word = hold_q;
    // Held word has priority; a direct P_DATA load only happens with hold empty.
    if (state_q == ST_IDLE) begin
      if (hold_full_q) begin
        load = 1'b1;
      end else if (hs) begin
        load      = 1'b1;
        bypass    = 1'b1;
        load_word = P_DATA;
      end
    end else if (last && hold_full_q) begin
      load = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:             if (load) state_d = ST_LOADED;
      ST_LOADED, ST_SHIFT: if (shift) begin
        if (last) state_d = load ? ST_LOADED : ST_IDLE;
        else      state_d = ST_SHIFT;
      end
      default:             state_d = ST_IDLE;
    endcase
    hold_full_d = (hold_full_q && !(load && !bypass)) || (hs && !bypass);
    hold_d      = (hs && !bypass) ? P_DATA : hold_q;
    par_d       = load ? parity_of(PAR_MAX_W'(load_word), par_odd) : par_q;
    done_d      = last;
    under_d     = idle_out;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      hold_full_q <= 1'b0;
      par_q       <= 1'b0;
      done_q      <= 1'b0;
      under_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_full_q <= hold_full_d;
      par_q       <= par_d;
      done_q      <= done_d;
      under_q     <= under_d;
    end
  end

  always_ff @(posedge clk) begin
    hold_q <= hold_d;
  end

  assign data_ready = !hold_full_q;
  assign busy       = (state_q != ST_IDLE) || hold_full_q;
  assign ser_done   = done_q;
  assign par_bit    = par_q;
  assign underrun   = under_q;

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: LSB-first (idle 0) and MSB-first (idle 1)
// instances share stimulus; directed scenarios plus a randomized model run.
module tb_piso_serializer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] P_DATA = 8'h00;
  logic       Data_Valid = 1'b0;
  logic       par_odd = 1'b0;
  logic       ser_en = 1'b0;
  logic [1:0] ready, sdat, done, par, busy, under;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  piso_serializer #(.DATA_WIDTH(8), .LSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .P_DATA(P_DATA), .Data_Valid(Data_Valid),
    .data_ready(ready[0]), .par_odd(par_odd), .ser_en(ser_en),
    .ser_data(sdat[0]), .ser_done(done[0]), .par_bit(par[0]),
    .busy(busy[0]), .underrun(under[0]));

  piso_serializer #(.DATA_WIDTH(8), .LSB_FIRST(1'b0), .IDLE_LEVEL(1'b1)) u_msb (
    .clk(clk), .rst(rst), .P_DATA(P_DATA), .Data_Valid(Data_Valid),
    .data_ready(ready[1]), .par_odd(par_odd), .ser_en(ser_en),
    .ser_data(sdat[1]), .ser_done(done[1]), .par_bit(par[1]),
    .busy(busy[1]), .underrun(under[1]));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; Data_Valid = 1'b0; ser_en = 1'b0; par_odd = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic send(input logic [7:0] w, input logic odd);
    P_DATA = w; par_odd = odd; Data_Valid = 1'b1;
    step();
    Data_Valid = 1'b0;
  endtask

  // ---------------- reference model ----------------
  bit         m_act [2];
  logic [7:0] m_cur [2];
  int         m_sent[2];
  bit         m_hv  [2];
  logic [7:0] m_hw  [2];
  logic       m_ser [2], m_done[2], m_par[2], m_und[2];

  function automatic logic idle_of(input int i);
    return (i == 0) ? 1'b0 : 1'b1;
  endfunction

  function automatic logic ones_parity(input logic [7:0] w);
    int n = 0;
    for (int b = 0; b < 8; b++) n += int'(w[b]);
    return (n % 2) == 1;
  endfunction

  task automatic model_load(input int i, input logic [7:0] w);
    m_act[i] = 1'b1; m_cur[i] = w; m_sent[i] = 0;
    m_par[i] = ones_parity(w) ^ par_odd;
  endtask

  // Advance the model by one clock edge using the inputs present before it.
  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      bit hs, took;
      int idx;
      if (rst) begin
        m_act[i] = 0; m_hv[i] = 0; m_sent[i] = 0; m_ser[i] = idle_of(i);
        m_done[i] = 0; m_par[i] = 0; m_und[i] = 0;
        continue;
      end
      hs = Data_Valid && !m_hv[i];
      took = 0; m_done[i] = 0; m_und[i] = 0;
      if (!m_act[i]) begin
        if (ser_en) begin m_ser[i] = idle_of(i); m_und[i] = 1; end
        if (m_hv[i]) begin model_load(i, m_hw[i]); m_hv[i] = 0; end
        else if (hs) begin model_load(i, P_DATA); took = 1; end
      end else if (ser_en) begin
        idx = (i == 0) ? m_sent[i] : 7 - m_sent[i];
        m_ser[i] = m_cur[i][idx];
        m_sent[i]++;
        if (m_sent[i] == 8) begin
          m_done[i] = 1; m_act[i] = 0;
          if (m_hv[i]) begin model_load(i, m_hw[i]); m_hv[i] = 0; end
        end
      end
      if (hs && !took) begin m_hv[i] = 1; m_hw[i] = P_DATA; end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 2; i++) begin
      checks++; if (ready[i] !== 1'b1) begin failures++; $display("FAIL reset_ready[%0d] got=%b exp=1", i, ready[i]); end
      checks++; if (sdat[i] !== idle_of(i)) begin failures++; $display("FAIL reset_ser[%0d] got=%b exp=%b", i, sdat[i], idle_of(i)); end
      checks++; if ({done[i], par[i], busy[i], under[i]} !== 4'b0000) begin failures++;
        $display("FAIL reset_flags[%0d] got=%b exp=0000", i, {done[i], par[i], busy[i], under[i]}); end
    end
  endtask

  task automatic test_lsb_first();
    logic [7:0] exp_bits = 8'b0000_0001;
    do_reset();
    send(8'h01, 1'b0);
    ser_en = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step();
      checks++; if (sdat[0] !== exp_bits[k]) begin failures++; $display("FAIL lsb_bit%0d got=%b exp=%b", k, sdat[0], exp_bits[k]); end
      checks++; if (done[0] !== (k == 7)) begin failures++; $display("FAIL lsb_done%0d got=%b exp=%b", k, done[0], k == 7); end
      checks++; if (par[0] !== 1'b1) begin failures++; $display("FAIL lsb_par%0d got=%b exp=1", k, par[0]); end
    end
    ser_en = 1'b0;
  endtask

  task automatic test_msb_first();
    logic [7:0] exp_bits = 8'b1000_0000;
    do_reset();
    send(8'h01, 1'b1);
    ser_en = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step();
      checks++; if (sdat[1] !== exp_bits[k]) begin failures++; $display("FAIL msb_bit%0d got=%b exp=%b", k, sdat[1], exp_bits[k]); end
      checks++; if (done[1] !== (k == 7)) begin failures++; $display("FAIL msb_done%0d got=%b exp=%b", k, done[1], k == 7); end
      checks++; if (par[1] !== 1'b0) begin failures++; $display("FAIL msb_par%0d got=%b exp=0", k, par[1]); end
    end
    ser_en = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp_bits = 16'b0000_1111_1111_0000;
    do_reset();
    P_DATA = 8'hF0; Data_Valid = 1'b1;
    step();
    checks++; if (ready[0] !== 1'b1) begin failures++; $display("FAIL b2b_ready_first got=%b exp=1", ready[0]); end
    P_DATA = 8'h0F;
    step();
    Data_Valid = 1'b0;
    checks++; if (ready[0] !== 1'b0) begin failures++; $display("FAIL b2b_ready_second got=%b exp=0", ready[0]); end
    par_odd = 1'b1;
    ser_en  = 1'b1;
    for (int k = 0; k < 16; k++) begin
      step();
      checks++; if (sdat[0] !== exp_bits[k]) begin failures++; $display("FAIL b2b_bit%0d got=%b exp=%b", k, sdat[0], exp_bits[k]); end
      checks++; if (done[0] !== (k == 7 || k == 15)) begin failures++; $display("FAIL b2b_done%0d got=%b", k, done[0]); end
      checks++; if (ready[0] !== (k >= 7)) begin failures++; $display("FAIL b2b_ready%0d got=%b exp=%b", k, ready[0], k >= 7); end
      checks++; if (par[0] !== (k >= 7)) begin failures++; $display("FAIL b2b_par%0d got=%b exp=%b", k, par[0], k >= 7); end
    end
    ser_en = 1'b0; par_odd = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [7:0] w [3];
    logic       exp_rdy;
    do_reset();
    for (int j = 0; j < 3; j++) w[j] = 8'($urandom);
    Data_Valid = 1'b1;
    P_DATA = w[0]; step();
    P_DATA = w[1]; step();
    P_DATA = w[2];
    for (int k = 0; k < 3; k++) begin
      step();
      checks++; if (ready[0] !== 1'b0) begin failures++; $display("FAIL bp_stall_ready%0d got=%b exp=0", k, ready[0]); end
    end
    ser_en = 1'b1;
    for (int k = 0; k < 24; k++) begin
      step();
      if (k == 8) Data_Valid = 1'b0;
      exp_rdy = (k == 7) || (k >= 15);
      checks++; if (sdat[0] !== w[k/8][k%8]) begin failures++; $display("FAIL bp_bit%0d got=%b exp=%b", k, sdat[0], w[k/8][k%8]); end
      checks++; if (ready[0] !== exp_rdy) begin failures++; $display("FAIL bp_ready%0d got=%b exp=%b", k, ready[0], exp_rdy); end
      checks++; if (done[0] !== (k % 8 == 7)) begin failures++; $display("FAIL bp_done%0d got=%b", k, done[0]); end
    end
    ser_en = 1'b0;
    step();
    checks++; if (busy[0] !== 1'b0) begin failures++; $display("FAIL bp_busy_end got=%b exp=0", busy[0]); end
  endtask

  task automatic test_pause();
    logic [7:0] w = 8'hA5;
    int         ndone = 0;
    do_reset();
    send(w, 1'b1);
    ser_en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step(); ndone += int'(done[0]);
      checks++; if (sdat[0] !== w[k]) begin failures++; $display("FAIL pause_pre_bit%0d got=%b exp=%b", k, sdat[0], w[k]); end
    end
    ser_en = 1'b0; par_odd = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step(); ndone += int'(done[0]);
      checks++; if (sdat[0] !== w[3]) begin failures++; $display("FAIL pause_hold_ser%0d got=%b exp=%b", k, sdat[0], w[3]); end
      checks++; if (par[0] !== 1'b1) begin failures++; $display("FAIL pause_hold_par%0d got=%b exp=1", k, par[0]); end
    end
    ser_en = 1'b1;
    for (int k = 4; k < 8; k++) begin
      step(); ndone += int'(done[0]);
      checks++; if (sdat[0] !== w[k]) begin failures++; $display("FAIL pause_post_bit%0d got=%b exp=%b", k, sdat[0], w[k]); end
    end
    ser_en = 1'b0;
    step(); ndone += int'(done[0]);
    checks++; if (ndone != 1) begin failures++; $display("FAIL pause_done_count got=%0d exp=1", ndone); end
  endtask

  task automatic test_underrun();
    do_reset();
    send(8'h80, 1'b0);
    ser_en = 1'b1;
    repeat (8) step();
    checks++; if (sdat[0] !== 1'b1) begin failures++; $display("FAIL un_last_bit got=%b exp=1", sdat[0]); end
    step();
    for (int i = 0; i < 2; i++) begin
      checks++; if (under[i] !== 1'b1) begin failures++; $display("FAIL un_flag[%0d] got=%b exp=1", i, under[i]); end
      checks++; if (sdat[i] !== idle_of(i)) begin failures++; $display("FAIL un_ser[%0d] got=%b exp=%b", i, sdat[i], idle_of(i)); end
    end
    ser_en = 1'b0;
    step();
    checks++; if (under !== 2'b00) begin failures++; $display("FAIL un_pulse_end got=%b exp=00", under); end
    P_DATA = 8'h03; Data_Valid = 1'b1; ser_en = 1'b1;
    step();
    Data_Valid = 1'b0;
    checks++; if ({under[0], busy[0], sdat[0]} !== 3'b110) begin failures++; $display("FAIL un_bypass got=%b exp=110", {under[0], busy[0], sdat[0]}); end
    step();
    checks++; if ({under[0], sdat[0]} !== 2'b01) begin failures++; $display("FAIL un_after_bypass got=%b exp=01", {under[0], sdat[0]}); end
    ser_en = 1'b0;
  endtask

  task automatic test_reset_midframe();
    do_reset();
    send(8'hFF, 1'b0);
    ser_en = 1'b1;
    repeat (4) step();
    rst = 1'b1; Data_Valid = 1'b1; P_DATA = 8'h5A;
    step();
    checks++; if ({sdat[0], done[0], par[0], busy[0], under[0], ready[0]} !== 6'b000001) begin failures++;
      $display("FAIL rstmid_outputs got=%b exp=000001", {sdat[0], done[0], par[0], busy[0], under[0], ready[0]}); end
    rst = 1'b0; Data_Valid = 1'b0; ser_en = 1'b0;
    step();
    checks++; if (busy[0] !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%b exp=0", busy[0]); end
    ser_en = 1'b1;
    step();
    checks++; if ({under[0], done[0]} !== 2'b10) begin failures++; $display("FAIL rstmid_discard got=%b exp=10", {under[0], done[0]}); end
    ser_en = 1'b0;
  endtask

  task automatic test_random();
    rst = 1'b1; Data_Valid = 1'b0; ser_en = 1'b0;
    model_edge();
    step();
    rst = 1'b0;
    for (int c = 0; c < 600; c++) begin
      rst        = ($urandom_range(0, 99) == 0);
      Data_Valid = $urandom_range(0, 1) == 1;
      P_DATA     = 8'($urandom);
      par_odd    = $urandom_range(0, 1) == 1;
      ser_en     = $urandom_range(0, 9) < 7;
      model_edge();
      step();
      for (int i = 0; i < 2; i++) begin
        checks++; if (sdat[i] !== m_ser[i]) begin failures++; $display("FAIL rnd_ser[%0d] cyc=%0d got=%b exp=%b", i, c, sdat[i], m_ser[i]); end
        checks++; if (done[i] !== m_done[i]) begin failures++; $display("FAIL rnd_done[%0d] cyc=%0d got=%b exp=%b", i, c, done[i], m_done[i]); end
        checks++; if (par[i] !== m_par[i]) begin failures++; $display("FAIL rnd_par[%0d] cyc=%0d got=%b exp=%b", i, c, par[i], m_par[i]); end
        checks++; if (under[i] !== m_und[i]) begin failures++; $display("FAIL rnd_under[%0d] cyc=%0d got=%b exp=%b", i, c, under[i], m_und[i]); end
        checks++; if (ready[i] !== !m_hv[i]) begin failures++; $display("FAIL rnd_ready[%0d] cyc=%0d got=%b exp=%b", i, c, ready[i], !m_hv[i]); end
        checks++; if (busy[i] !== (m_act[i] || m_hv[i])) begin failures++;
          $display("FAIL rnd_busy[%0d] cyc=%0d got=%b exp=%b", i, c, busy[i], m_act[i] || m_hv[i]); end
      end
    end
    rst = 1'b0; Data_Valid = 1'b0; ser_en = 1'b0;
  endtask

  initial begin
    #1;
    test_reset();
    test_lsb_first();
    test_msb_first();
    test_back_to_back();
    test_backpressure();
    test_pause();
    test_underrun();
    test_reset_midframe();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
